// File: rtl/yout_frame_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : yout_frame_deserializer
// Brief    : Hunts a sync word in the serial Yout stream, assembles the frame's
//            data bytes and queues them in a FIFO behind a valid/ready port.
//            Define YOUT_FRAME_PARITY_EN for a trailing even-parity bit per byte.
// Revision : 1.0 - initial release
// =============================================================================
module yout_frame_deserializer #(
  parameter logic [7:0] SYNC_WORD  = 8'hA5,
  parameter int         FRAME_LEN  = 4,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bit_in,
  input  logic                          bit_en,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_start,
  output logic                          in_frame,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef YOUT_FRAME_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = c_aw + 1;
`ifdef YOUT_FRAME_PARITY_EN
  localparam int c_bits = 9;
`else
  localparam int c_bits = 8;
`endif
  localparam logic [3:0]      c_last_bit  = 4'(c_bits - 1);
  localparam logic [3:0]      c_last_byte = 4'(FRAME_LEN - 1);
  localparam logic [c_aw:0]   c_full      = c_cw'(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_cnt_one   = c_cw'(1);
  localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);

  localparam logic [0:0] c_st_hunt    = 1'b0;
  localparam logic [0:0] c_st_collect = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_next;
  // Only the 7 most recent bits are kept; the 8th comes straight from bit_in.
  logic [6:0]        r_hist;
  logic [7:0]        w_hist_next;
  logic [c_bits-2:0] r_asm;
  logic [c_bits-1:0] w_asm_next;
  logic [3:0]        r_bit_cnt;
  logic [3:0]        r_byte_cnt;
  logic              r_frame_start;
  logic              w_sync_hit;
  logic              w_byte_done;
  logic              w_frame_done;
  logic              w_byte_ok;
  logic [7:0]        w_byte;
  logic              w_push_req;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;
  logic              r_overflow;
  logic              w_pop;
  logic              w_full;
  logic              w_wr;
`ifdef YOUT_FRAME_PARITY_EN
  logic              r_parity_err;
`endif

  always_comb begin
    w_hist_next  = {r_hist, bit_in};
    w_asm_next   = {r_asm, bit_in};
    w_sync_hit   = bit_en && (r_state == c_st_hunt) && (w_hist_next == SYNC_WORD);
    w_byte_done  = bit_en && (r_state == c_st_collect) && (r_bit_cnt == c_last_bit);
    w_frame_done = w_byte_done && (r_byte_cnt == c_last_byte);
`ifdef YOUT_FRAME_PARITY_EN
    w_byte       = w_asm_next[8:1];
    w_byte_ok    = ~^w_asm_next;
`else
    w_byte       = w_asm_next;
    w_byte_ok    = 1'b1;
`endif
    w_push_req   = w_byte_done && w_byte_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_hunt;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_hunt:    if (w_sync_hit)   w_state_next = c_st_collect;
      c_st_collect: if (w_frame_done) w_state_next = c_st_hunt;
      default:      w_state_next = c_st_hunt;
    endcase
  end

  always_comb begin
    in_frame    = (r_state == c_st_collect);
    frame_start = r_frame_start;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist        <= '0;
      r_asm         <= '0;
      r_bit_cnt     <= '0;
      r_byte_cnt    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_sync_hit;
      if (bit_en) begin
        if (r_state == c_st_hunt) begin
          r_hist <= w_hist_next[6:0];
          if (w_sync_hit) begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
          end
        end else begin
          r_asm <= w_asm_next[c_bits-2:0];
          if (w_byte_done) begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= w_frame_done ? 4'd0 : r_byte_cnt + 4'd1;
            if (w_frame_done) r_hist <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
      end
    end
  end

`ifdef YOUT_FRAME_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parity_err <= 1'b0;
    end else if (w_byte_done && !w_byte_ok) begin
      r_parity_err <= 1'b1;
    end
  end
  assign parity_err = r_parity_err;
`endif

  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_pop  = out_valid && out_ready;
  assign w_full = (r_count == c_full);
  assign w_wr   = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_byte;
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_push_req && !w_wr) r_overflow <= 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_data   = r_mem[r_rd_ptr];
  assign out_valid  = (r_count != '0);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire
